// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: pipeline records, memory FSM states and access-size constants
package mem_access_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
  } ctl_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] rd2;
  } excute_data_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] addr;
  } memory_data_t;
  typedef struct packed {
    logic        ismem;
    logic [4:0]  dst;
    logic [63:0] data;
  } tran_t;
  function automatic logic is_mem(ctl_t c);
    return c.memread | c.memwrite;
  endfunction
endpackage

// File: rtl/mem_access_unit_align.sv
// mem_align: store lane steering and load extraction/extension for one bus word
module mem_align import mem_access_unit_pkg::*; (
  input  logic [2:0]  i_funct3,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_rd2,
  input  logic [63:0] i_rdata,
  output logic [2:0]  o_size,
  output logic [7:0]  o_mask,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);
  logic [63:0] w_raw;
  assign o_size = i_funct3[1:0] == 2'd0 ? MSIZE1 : i_funct3[1:0] == 2'd1 ? MSIZE2 :
                  i_funct3[1:0] == 2'd2 ? MSIZE4 : MSIZE8;
  assign o_mask = (o_size == MSIZE1 ? 8'h01 : o_size == MSIZE2 ? 8'h03 :
                   o_size == MSIZE4 ? 8'h0F : 8'hFF) << i_off;
  assign o_wdata = i_rd2 << {i_off, 3'b000};
  assign w_raw = i_rdata >> {i_off, 3'b000};
  // Extend the addressed bytes to 64 bits, signed or unsigned by funct3
  always_comb begin
    o_rdata = w_raw;
    case (i_funct3)
      F3_LB:   o_rdata = {{56{w_raw[7]}}, w_raw[7:0]};
      F3_LH:   o_rdata = {{48{w_raw[15]}}, w_raw[15:0]};
      F3_LW:   o_rdata = {{32{w_raw[31]}}, w_raw[31:0]};
      F3_LBU:  o_rdata = {56'd0, w_raw[7:0]};
      F3_LHU:  o_rdata = {48'd0, w_raw[15:0]};
      F3_LWU:  o_rdata = {32'd0, w_raw[31:0]};
      F3_LD:   o_rdata = w_raw;
      default: o_rdata = w_raw;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage, runs LD/SD bus transactions and passes ALU results through
module mem_access_unit import mem_access_unit_pkg::*; #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  excute_data_t      ex_in,
  output logic              ex_ready,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [63:0]       dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [63:0]       dresp_data,
  output memory_data_t      mem_out,
  output tran_t             fwd
);
  mem_state_t   r_state;
  excute_data_t r_cur;
  memory_data_t r_mem_out;
  logic         w_busy;
  logic         w_done;
  logic [7:0]   w_mask;
  logic [63:0]  w_load;
  assign w_busy = r_state != IDLE;
  assign w_done = (r_state == REQ && dresp_addr_ok && dresp_data_ok) || (r_state == WAIT && dresp_data_ok);
  assign ex_ready = r_state == IDLE;
  assign dreq_valid = w_busy;
  assign dreq_addr = {r_cur.result[ADDR_W-1:3], 3'b000};
  assign dreq_strobe = w_busy && r_cur.ctl.memwrite ? w_mask : 8'd0;
  assign mem_out = r_mem_out;
  mem_align u_align (
    .i_funct3(r_cur.instr[14:12]),
    .i_off   (r_cur.result[2:0]),
    .i_rd2   (r_cur.rd2),
    .i_rdata (dresp_data),
    .o_size  (dreq_size),
    .o_mask  (w_mask),
    .o_wdata (dreq_data),
    .o_rdata (w_load)
  );
  // Accept from execute, walk the bus handshake, register the writeback record
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cur <= '0;
      r_mem_out <= '0;
    end else begin
      r_mem_out.valid <= 1'b0;
      case (r_state)
        IDLE: if (ex_in.valid && is_mem(ex_in.ctl)) begin
          r_cur <= ex_in;
          r_state <= REQ;
        end else if (ex_in.valid) begin
          r_mem_out <= '{valid: 1'b1, pc: ex_in.pc, instr: ex_in.instr, ctl: ex_in.ctl,
                         dst: ex_in.dst, result: ex_in.result, addr: 64'd0};
        end
        REQ: if (dresp_addr_ok) r_state <= dresp_data_ok ? IDLE : WAIT;
        WAIT: if (dresp_data_ok) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_done)
        r_mem_out <= '{valid: 1'b1, pc: r_cur.pc, instr: r_cur.instr, ctl: r_cur.ctl, dst: r_cur.dst,
                       result: r_cur.ctl.memread ? w_load : r_cur.result, addr: r_cur.result};
    end
  end
  // Forwarding record: in-flight load destination while busy, else the registered result
  always_comb begin
    fwd.ismem = w_busy;
    fwd.dst = w_busy ? (r_cur.ctl.regwrite ? r_cur.dst : 5'd0) :
              (r_mem_out.valid && r_mem_out.ctl.regwrite ? r_mem_out.dst : 5'd0);
    fwd.data = w_busy ? 64'd0 : r_mem_out.result;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench with a byte-level memory reference model
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  logic         clk = 0;
  logic         reset = 1;
  excute_data_t ex_in;
  logic         ex_ready, dreq_valid;
  logic [63:0]  dreq_addr, dreq_data;
  logic [2:0]   dreq_size;
  logic [7:0]   dreq_strobe;
  logic         dresp_addr_ok = 0, dresp_data_ok = 0;
  logic [63:0]  dresp_data = 0;
  memory_data_t mem_out;
  tran_t        fwd;

  mem_access_unit #(.ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .ex_in(ex_in), .ex_ready(ex_ready),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mem_out(mem_out), .fwd(fwd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [63:0] data;
    logic [4:0]  fdst;
  } req_t;
  typedef struct {
    logic [63:0] pc;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] addr;
    logic [4:0]  fdst;
  } out_t;

  req_t        req_q[$];
  out_t        out_q[$];
  logic [7:0]  ref_mem[256];
  logic [63:0] slv_mem[32];
  int n_chk = 0, n_pass = 0, n_out = 0;
  int f_ad = -1, f_dd = -1;
  bit late_ok = 0, no_spur = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_word(input logic [63:0] a, input logic [63:0] w);
    slv_mem[a[7:3]] = w;
    for (int i = 0; i < 8; i++) ref_mem[{a[7:3], 3'b000} + 8'(i)] = w[8*i +: 8];
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [2:0] f3);
    int n = 1 << f3[1:0];
    logic [63:0] v = 0;
    for (int i = 0; i < n; i++) v |= 64'(ref_mem[a[7:0] + 8'(i)]) << (8 * i);
    if (!f3[2] && n < 8 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  // kind: 0 ALU, 1 load, 2 store
  task automatic issue(input int kind, input logic [2:0] f3, input logic [63:0] res,
                       input logic [63:0] rd2, input logic [4:0] dst, input logic rw);
    excute_data_t op;
    int t = 0;
    int n = 1 << f3[1:0];
    logic [7:0] s = 0;
    logic [4:0] fdst;
    op.valid = 1'b1;
    op.pc = {32'($urandom), 32'($urandom)};
    op.instr = {17'($urandom), f3, dst, kind == 0 ? 7'h33 : kind == 1 ? 7'h03 : 7'h23};
    op.ctl = kind == 0 ? '{regwrite: rw, memread: 1'b0, memwrite: 1'b0} :
             kind == 1 ? '{regwrite: 1'b1, memread: 1'b1, memwrite: 1'b0} :
                         '{regwrite: 1'b0, memread: 1'b0, memwrite: 1'b1};
    op.dst = dst;
    op.result = res;
    op.rd2 = rd2;
    fdst = op.ctl.regwrite ? dst : 5'd0;
    @(negedge clk);
    ex_in = op;
    #1;
    while (!ex_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("accept", ex_ready, 1);
    if (!ex_ready) begin
      ex_in.valid = 0;
      return;
    end
    if (kind == 0) out_q.push_back('{op.pc, dst, res, 64'd0, fdst});
    else begin
      if (kind == 2) for (int i = 0; i < n; i++) s[int'(res[2:0]) + i] = 1'b1;
      req_q.push_back('{{res[63:3], 3'b000}, {1'b0, f3[1:0]}, s, rd2 << (8 * res[2:0]), fdst});
      out_q.push_back('{op.pc, dst, kind == 1 ? ref_load(res, f3) : res, res, fdst});
      if (kind == 2) for (int i = 0; i < n; i++) ref_mem[res[7:0] + 8'(i)] = rd2[8*i +: 8];
    end
    @(posedge clk);
    #1;
    ex_in.valid = 0;
  endtask

  task automatic wait_out(input string name, input logic [63:0] exp);
    int t = 0;
    while (!mem_out.valid && t < 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (mem_out.valid) chk(name, mem_out.result, exp);
    else chk({name, "_timeout"}, mem_out.valid, 1);
  endtask

  // Bus slave: checks each request against the model, holds it for a random handshake, applies stores
  bit         in_txn = 0;
  int         k, ad, dd;
  req_t       ef, snap;
  always @(negedge clk) begin
    if (reset) begin
      in_txn = 0;
      dresp_addr_ok = 0;
      dresp_data_ok = 0;
    end else if (dreq_valid) begin
      if (!in_txn) begin
        in_txn = 1;
        k = 0;
        ef = '{0, 0, 0, 0, 0};
        chk("req_expected", req_q.size() != 0, 1);
        if (req_q.size() != 0) ef = req_q.pop_front();
        chk("req_addr", dreq_addr, ef.addr);
        chk("req_size", dreq_size, ef.size);
        chk("req_strobe", dreq_strobe, ef.strb);
        chk("req_data", dreq_data, ef.data);
        snap = '{dreq_addr, dreq_size, dreq_strobe, dreq_data, 0};
        ad = f_ad >= 0 ? f_ad : int'($urandom_range(0, 2));
        dd = f_dd >= 0 ? f_dd : int'($urandom_range(0, 3));
      end else
        chk("req_stable", dreq_addr == snap.addr && dreq_size == snap.size &&
            dreq_strobe == snap.strb && dreq_data == snap.data, 1);
      chk("busy_fwd_ismem", fwd.ismem, 1);
      chk("busy_fwd_dst", fwd.dst, ef.fdst);
      chk("busy_fwd_data", fwd.data, 0);
      chk("busy_ex_ready", ex_ready, 0);
      dresp_addr_ok = k == ad;
      dresp_data_ok = k == ad + dd || (k < ad && !no_spur && $urandom_range(0, 3) == 0);
      dresp_data = {32'($urandom), 32'($urandom)};
      if (k == ad + dd) begin
        for (int b = 0; b < 8; b++)
          if (dreq_strobe[b]) slv_mem[dreq_addr[7:3]][8*b +: 8] = dreq_data[8*b +: 8];
        dresp_data = slv_mem[dreq_addr[7:3]];
        in_txn = 0;
      end
      k++;
    end else begin
      dresp_addr_ok = 0;
      dresp_data_ok = late_ok;
      dresp_data = {32'($urandom), 32'($urandom)};
    end
  end

  // Monitor: every writeback pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!reset && mem_out.valid) begin
      out_t e;
      n_out++;
      chk("out_expected", out_q.size() != 0, 1);
      if (out_q.size() != 0) begin
        e = out_q.pop_front();
        chk("out_result", mem_out.result, e.result);
        chk("out_addr", mem_out.addr, e.addr);
        chk("out_dst", mem_out.dst, e.dst);
        chk("out_pc", mem_out.pc, e.pc);
        if (!dreq_valid) begin
          chk("out_fwd_ismem", fwd.ismem, 0);
          chk("out_fwd_dst", fwd.dst, e.fdst);
          chk("out_fwd_data", fwd.data, e.result);
        end
      end
    end
  end

  initial begin
    int cnt;
    ex_in = '0;
    for (int i = 0; i < 32; i++) set_word(64'(i * 8), {32'($urandom), 32'($urandom)});
    set_word(64'h2000, 64'h0000_0000_8000_0000);
    set_word(64'h2010, 64'h1111_2222_9ABC_DEF0);
    #12;
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_dreq_strobe", dreq_strobe, 0);
    chk("rst_out_valid", mem_out.valid, 0);
    chk("rst_out_result", mem_out.result, 0);
    chk("rst_fwd_ismem", fwd.ismem, 0);
    chk("rst_fwd_dst", fwd.dst, 0);
    chk("rst_fwd_data", fwd.data, 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_ex_ready", ex_ready, 1);

    issue(0, 3'b000, 64'h1234, 64'd0, 5'd5, 1'b1);
    @(negedge clk);
    #1;
    chk("alu_ready", ex_ready, 1);
    chk("alu_valid", mem_out.valid, 1);
    chk("alu_result", mem_out.result, 64'h1234);
    chk("alu_fwd_dst", fwd.dst, 5);
    chk("alu_fwd_ismem", fwd.ismem, 0);

    issue(1, F3_LB, 64'h2003, 64'd0, 5'd7, 1'b1);
    wait_out("lb_result", 64'hFFFF_FFFF_FFFF_FF80);
    issue(1, F3_LBU, 64'h2003, 64'd0, 5'd8, 1'b1);
    wait_out("lbu_result", 64'h80);
    issue(2, 3'b001, 64'h2006, 64'hABCD, 5'd0, 1'b0);
    wait_out("sh_result", 64'h2006);

    f_ad = 0;
    f_dd = 0;
    issue(2, F3_LD, 64'h1000, 64'hDEAD_BEEF_CAFE_BABE, 5'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("sd_ready_busy", ex_ready, 0);
    chk("sd_dreq_valid", dreq_valid, 1);
    chk("sd_out_early", mem_out.valid, 0);
    @(negedge clk);
    #1;
    chk("sd_out_valid", mem_out.valid, 1);
    chk("sd_ready_after", ex_ready, 1);

    f_dd = 3;
    issue(1, F3_LW, 64'h2010, 64'd0, 5'd9, 1'b1);
    wait_out("lw_result", 64'hFFFF_FFFF_9ABC_DEF0);

    f_dd = 1000;
    no_spur = 1;
    issue(1, F3_LD, 64'h2020, 64'd0, 5'd10, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1;
    #1;
    chk("rst_mid_dreq_valid", dreq_valid, 0);
    chk("rst_mid_out_valid", mem_out.valid, 0);
    out_q.delete();
    req_q.delete();
    cnt = n_out;
    @(negedge clk);
    #2;
    reset = 0;
    late_ok = 1;
    @(negedge clk);
    #2;
    late_ok = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("late_ok_no_out", n_out, cnt);
    chk("late_ok_ready", ex_ready, 1);

    f_ad = -1;
    f_dd = -1;
    no_spur = 0;
    for (int it = 0; it < 300; it++) begin
      int kind = int'($urandom_range(0, 2));
      logic [2:0] f3 = kind == 1 ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      logic [63:0] a = {32'($urandom), 32'($urandom)};
      if (kind != 0) a = a & ~64'((1 << f3[1:0]) - 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(kind, f3, a, {32'($urandom), 32'($urandom)}, 5'($urandom), 1'($urandom));
    end
    repeat (12) @(negedge clk);
    chk("pending_out", out_q.size(), 0);
    chk("pending_req", req_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory stage of the five-stage RV64 pipeline. Accepts one `excute_data_t` per transaction from execute, performs the data-bus access for LD/SD-class instructions (byte/half/word/double, signed/unsigned) and passes ALU-class instructions through. It produces a registered `memory_data_t` for writeback and a `tran_t` forwarding record for the hazard unit. It stalls execute while a bus transaction is outstanding.

## Interface
Parameters:
- `ADDR_W`, 64: data-bus address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `ex_in` in `excute_data_t`: instruction from execute; qualified by `ex_in.valid`.
- `ex_ready` out 1: stage can accept `ex_in` this cycle.
- `dreq_valid` out 1: data-bus request valid.
- `dreq_addr` out ADDR_W: byte address, with the low 3 bits cleared.
- `dreq_size` out 3: log2 of the access bytes (0..3).
- `dreq_strobe` out 8: byte-write enables; 0 for loads.
- `dreq_data` out 64: store data, lane-shifted.
- `dresp_addr_ok` in 1: request address accepted.
- `dresp_data_ok` in 1: transaction complete; for loads, `dresp_data` is valid.
- `dresp_data` in 64: load data, aligned to the 8-byte word.
- `mem_out` out `memory_data_t`: registered result to writeback.
- `fwd` out `tran_t`: forwarding record to the hazard/forward unit.

## Operation
- FSM states are `IDLE`, `REQ` and `WAIT` (`mem_state_t`).
- **IDLE:**
  - `ex_ready=1`.
  - If `ex_in.valid` and the op is not LD/SD: capture into `mem_out` directly (`valid=1`, `result=ex_in.result`, `addr=0`). Stay in IDLE.
  - If `ex_in.valid` and the op is LD/SD: capture into internal register `cur`, clear `mem_out.valid`, and go to REQ.
  - No valid input: `mem_out.valid<=0`.
- **REQ:**
  - `ex_ready=0` and `dreq_valid=1`. All `dreq_*` fields come from `cur` and stay stable.
  - `addr_ok` without `data_ok`: go to WAIT.
  - `addr_ok` with `data_ok`: complete the transaction.
  - `data_ok` without `addr_ok`: ignored.
- **WAIT:**
  - `dreq_valid` stays 1 with stable fields (the bus protocol holds valid until `data_ok`).
  - On `data_ok`: complete the transaction.
- **Complete:**
  - Write `mem_out` with `pc/instr/ctl/dst` from `cur`, `addr=cur.result`, `valid=1`.
  - For loads, `result` is the extended load data; for stores, `result=cur.result`.
  - Go to IDLE.
- **Size and sign** come from `funct3=instr[14:12]`:
  - 000/100: 1 byte, signed/unsigned.
  - 001/101: 2 bytes, signed/unsigned.
  - 010/110: 4 bytes, signed/unsigned.
  - 011: 8 bytes.
- **Lane arithmetic**, with `off=cur.result[2:0]`:
  - `dreq_data = rd2 << (8*off)`.
  - `dreq_strobe = ((1<<bytes)-1) << off`, truncated to 8 bits.
  - Load: `raw = dresp_data >> (8*off)`, then sign- or zero-extend from the access width to 64.
- **Alignment:** accesses are naturally aligned. Misaligned results are unspecified and not checked.
- **fwd:**
  - While in REQ/WAIT: `ismem=1`, `dst = cur.ctl.regwrite ? cur.dst : 0`, `data=0`.
  - Otherwise: `ismem=0`, `dst = (mem_out.valid && mem_out.ctl.regwrite) ? mem_out.dst : 0`, `data=mem_out.result`.
- **Downstream:** writeback always accepts. `mem_out.valid` is high for exactly one cycle per instruction.

## Timing
- Reset, applied asynchronously:
  - `state=IDLE`.
  - `cur`, `mem_out` and `fwd` all zero.
  - `dreq_valid=0`, `dreq_strobe=0`.
  - `ex_ready=1` once reset deasserts.
- ALU-class latency: `mem_out.valid` rises 1 cycle after acceptance.
- Memory latency: accept edge, then ≥1 cycle in REQ. `mem_out.valid` rises on the edge after `data_ok` is sampled.
  - Best case, with `addr_ok=data_ok=1` in the first REQ cycle: `mem_out.valid` rises 2 cycles after acceptance.
- `ex_ready` is combinational from state only. It never depends on `dresp_*`.
- Back-to-back: the cycle after completion is IDLE, so the next instruction is accepted then. Throughput is 1 ALU op per cycle.
- Reset mid-transaction: `dreq_valid` drops immediately. Any later `data_ok` is ignored in IDLE.

## Structure
- Additions to the shared `pipes` package:
  - `mem_state_t` (IDLE/REQ/WAIT).
  - Constants `F3_LB..F3_LWU`.
  - Constants `MSIZE1/2/4/8`.
- One sub-module, `mem_align`: purely combinational. Takes funct3, offset, `rd2` and `dresp_data`; produces size, strobe, shifted store data and extended load data.
- Top holds the FSM, `cur` and `mem_out`; about 200 RTL lines total.

## Test plan
- ALU op (`result=0x1234`, dst=5, regwrite) accepted in IDLE → next cycle `mem_out.valid=1`, `result=0x1234`; `fwd.dst=5`, `fwd.ismem=0`; `ex_ready` stays 1.
- SD at `0x1000` with `rd2=0xDEADBEEF_CAFEBABE` → `dreq_valid=1`, `addr=0x1000`, `size=3`, `strobe=0xFF`, data unchanged. `addr_ok` and `data_ok` both arrive in cycle 1 → `mem_out.valid` on the next edge; `ex_ready=0` until then.
- LB at `0x2003`, `dresp_data=0x00000000_80000000` → `strobe=0`, `size=0`, `result=0xFFFFFFFFFFFFFF80`. LBU with the same data → `0x80`.
- SH at `0x2006`, `rd2=0xABCD` → `strobe=0xC0`, `dreq_data=0xABCD_000000000000`.
- LW with `addr_ok` in cycle 1 and `data_ok` 3 cycles later → `dreq` fields stable throughout, `fwd.ismem=1` during the wait, one `mem_out.valid` pulse with the sign-extended word.
- `reset` asserted in WAIT → `dreq_valid` falls the same cycle, `mem_out.valid=0`. A late `data_ok` after reset produces no output.
